// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: active-low segment
// patterns for hex digits, the blank pattern and the anode-off level.
package seg7_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam logic ANODE_OFF = 1'b1;

    // Element k holds the {g,f,e,d,c,b,a} active-low pattern for hex digit k.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed hex display scanner with a double-buffered display word
// that only changes at frame boundaries, so a frame never shows two words.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 4 * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [IDX_W-1:0]      idx_reg;
    logic [IDX_W-1:0]      idx_next;
    logic [DATA_W-1:0]     shadow_reg;
    logic [DATA_W-1:0]     shadow_next;
    logic [DATA_W-1:0]     disp_reg;
    logic [DATA_W-1:0]     disp_next;
    logic                  pending_reg;
    logic                  pending_next;
    logic                  wrap;
    logic [3:0]            nibble;
    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] an_next;

    assign idx_next = idx_reg + IDX_W'(1);
    assign wrap     = (idx_next == '0);

    // A load on the wrap tick bypasses the shadow and wins over a pending word.
    always_comb begin
        shadow_next  = shadow_reg;
        disp_next    = disp_reg;
        pending_next = pending_reg;
        if (clk_en && wrap) begin
            if (load) begin
                disp_next = data_in;
            end else if (pending_reg) begin
                disp_next = shadow_reg;
            end
            pending_next = 1'b0;
        end else if (load) begin
            shadow_next  = data_in;
            pending_next = 1'b1;
        end
    end

    // Decode from the post-commit word so digit 0 of a new frame is current.
    assign nibble = disp_next[{idx_next, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .hex (nibble),
        .seg (seg_dec)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_next[gi] = (idx_next == IDX_W'(gi)) ? ~ANODE_OFF : ANODE_OFF;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_reg     <= IDX_W'(NUM_DIGITS - 1);
            shadow_reg  <= '0;
            disp_reg    <= '0;
            pending_reg <= 1'b0;
            an          <= {NUM_DIGITS{ANODE_OFF}};
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            shadow_reg  <= shadow_next;
            disp_reg    <= disp_next;
            pending_reg <= pending_next;
            frame_done  <= clk_en & wrap;
            if (clk_en) begin
                idx_reg <= idx_next;
                an      <= an_next;
                seg     <= seg_dec;
                dp      <= ~dp_mask[idx_next];
            end
        end
    end

    assign pending = pending_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus pushes expected outputs from a
// behavioural display model, a monitor pops and compares after every edge.
module tb_seg7_scan;

    localparam int NUM = 8;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    seg7_scan #(.NUM_DIGITS(NUM)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .load       (load),
        .data_in    (data_in),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          started = 0;
    bit          done = 0;
    logic [6:0]  seg_tbl [16];
    logic [7:0]  cur_mask = 8'h00;

    // Reference model state: which digit is lit and what the display holds.
    int          m_digit;
    logic [31:0] m_disp, m_shadow;
    logic        m_pend, m_fd, m_dp;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t cur_exp();
        exp_t e;
        e.an = m_an; e.seg = m_seg; e.dp = m_dp; e.fd = m_fd; e.pend = m_pend;
        return e;
    endfunction

    task automatic model_reset();
        m_digit = NUM - 1;
        m_disp = '0; m_shadow = '0; m_pend = 0; m_fd = 0;
        m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1;
    endtask

    task automatic model_step(input logic ce, input logic ld, input logic [31:0] din,
                              input logic [7:0] mask);
        int  nd;
        logic w;
        nd = (m_digit + 1) % NUM;
        w  = ce && (nd == 0);
        m_fd = w;
        if (w) begin
            if (ld) m_disp = din;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 0;
        end else if (ld) begin
            m_shadow = din;
            m_pend   = 1;
        end
        if (ce) begin
            m_digit = nd;
            m_an  = 8'hFF ^ (8'h01 << nd);
            m_seg = seg_tbl[(m_disp >> (4 * nd)) & 32'hF];
            m_dp  = ~mask[nd];
        end
    endtask

    task automatic step(input logic ce, input logic ld, input logic [31:0] din);
        @(negedge clk);
        clk_en = ce; load = ld; data_in = din; dp_mask = cur_mask;
        model_step(ce, ld, din, cur_mask);
        exp_q.push_back(cur_exp());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0);
    endtask

    task automatic advance_to(input int d);
        while (m_digit != d) step(1, 0, 32'h0);
    endtask

    // Asserts reset between edges: the first expectation is checked with no clock edge.
    task automatic do_reset();
        @(negedge clk);
        started = 1;
        reset = 0; clk_en = 0; load = 0;
        model_reset();
        exp_q.push_back(cur_exp());
        exp_q.push_back(cur_exp());
        @(negedge clk);
        exp_q.push_back(cur_exp());
        @(negedge clk);
        reset = 1;
        exp_q.push_back(cur_exp());
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (exp_q.size() == 0) begin
                if (started && !done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow cycle %0d: got empty queue, expected an entry", cyc);
                end
            end else begin
                e = exp_q.pop_front();
                check("an", int'(an), int'(e.an));
                check("seg", int'(seg), int'(e.seg));
                check("dp", int'(dp), int'(e.dp));
                check("frame_done", int'(frame_done), int'(e.fd));
                check("pending", int'(pending), int'(e.pend));
            end
        end
    end

    initial begin : stimulus
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();

        do_reset();
        idle(20);

        // Digit sequence: 9 ticks spaced 5 cycles
        step(0, 1, 32'h1234ABCD);
        for (int t = 0; t < 9; t++) begin
            idle(4);
            step(1, 0, 32'h0);
        end

        // Mid-frame load held until the next boundary
        advance_to(3);
        step(0, 1, 32'hFFFFFFFF);
        for (int t = 0; t < 12; t++) step(1, 0, 32'h0);

        // Load on the wrap tick commits directly
        advance_to(7);
        step(1, 1, 32'h00000007);
        idle(2);

        // Last load wins; decimal point on digit 0 only
        cur_mask = 8'h01;
        advance_to(5);
        step(0, 1, 32'h00000001);
        step(1, 0, 32'h0);
        step(0, 1, 32'h00000002);
        advance_to(7);
        for (int t = 0; t < 9; t++) step(1, 0, 32'h0);
        cur_mask = 8'h00;

        // Async reset mid-frame with a pending word
        advance_to(3);
        step(0, 1, 32'hDEADBEEF);
        advance_to(5);
        do_reset();
        idle(2);
        step(1, 0, 32'h0);
        idle(2);

        // Randomised traffic, sparse ticks then back-to-back ticks
        for (int i = 0; i < 400; i++) begin
            cur_mask = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom);
        end
        for (int i = 0; i < 60; i++) begin
            cur_mask = 8'($urandom_range(0, 255));
            step(1, ($urandom_range(0, 5) == 0), $urandom);
        end
        idle(3);

        @(posedge clk);
        #2;
        done = 1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
